// File: rtl/parallel_counter_pkg.sv
// rtl/parallel_counter_pkg.sv - shared types and widths for the parallel counter block
//
// Contents:
//   CNT_W      width of every counter value
//   cnt_t      counter value type
//   cnt_dir_e  counting direction selected per cell

package parallel_counter_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        CNT_UP,
        CNT_DOWN
    } cnt_dir_e;

endpackage : parallel_counter_pkg

// File: rtl/parallel_counter_cell.sv
// rtl/parallel_counter_cell.sv - one free-running modulo counter, up or down
//
// Parameters:
//   MAX_COUNT  modulus; the count runs over 0..MAX_COUNT-1
//   DIR        CNT_UP counts 0,1,..,MAX_COUNT-1,0 ; CNT_DOWN counts MAX_COUNT-1,..,0,MAX_COUNT-1
// Ports:
//   clk    in   clock, all state on posedge
//   rst_n  in   synchronous active-low reset
//   count  out  registered count value
//   wrap   out  registered pulse, high in the cycle after the count wrapped

module parallel_counter_cell
    import parallel_counter_pkg::*;
#(
    parameter int       MAX_COUNT = 8,
    parameter cnt_dir_e DIR       = CNT_UP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    // MAX_COUNT-1 truncated to the counter width, so a modulus of 16 maps
    // to 15 and the 4-bit arithmetic wraps naturally.
    localparam cnt_t TOP_VAL   = cnt_t'(MAX_COUNT - 1);

    // The value an up-counter leaves on wrap is its top; a down-counter
    // leaves zero. The value it lands on is the opposite end, which is
    // also the reset value.
    localparam cnt_t RST_VAL   = (DIR == CNT_UP) ? cnt_t'(0) : TOP_VAL;
    localparam cnt_t WRAP_FROM = (DIR == CNT_UP) ? TOP_VAL : cnt_t'(0);

    logic at_end;
    cnt_t count_next;

    always_comb begin
        at_end     = (count == WRAP_FROM);
        count_next = count;
        if (at_end) begin
            count_next = RST_VAL;
        end else if (DIR == CNT_UP) begin
            count_next = count + cnt_t'(1);
        end else begin
            count_next = count - cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= RST_VAL;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= at_end;
        end
    end

endmodule : parallel_counter_cell

// File: rtl/parallel_counter.sv
// rtl/parallel_counter.sv - two independent modulo counters, one up and one down, on a shared clock
//
// Build option: PARALLEL_COUNTER_WRAP_FLAGS_EN adds the wrap1/wrap2 pulse outputs.
// Parameters:
//   MAX_COUNT  modulus of both counters, legal 2..16
// Ports:
//   clk       in   clock, all state on posedge
//   rst_n     in   synchronous active-low reset
//   counter1  out  up-counter, resets to 0
//   counter2  out  down-counter, resets to MAX_COUNT-1
//   wrap1     out  (option) pulse in the cycle after counter1 wrapped to 0
//   wrap2     out  (option) pulse in the cycle after counter2 wrapped to MAX_COUNT-1

module parallel_counter
    import parallel_counter_pkg::*;
#(
    parameter int MAX_COUNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] counter1,
    output logic [CNT_W-1:0] counter2
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
    ,
    output logic             wrap1,
    output logic             wrap2
`endif
);

    if (MAX_COUNT < 2 || MAX_COUNT > (1 << CNT_W)) begin : g_bad_max_count
        $error("parallel_counter: MAX_COUNT=%0d outside legal range 2..%0d",
               MAX_COUNT, (1 << CNT_W));
    end

    logic wrap_up;
    logic wrap_dn;

    parallel_counter_cell #(
        .MAX_COUNT (MAX_COUNT),
        .DIR       (CNT_UP)
    ) u_cnt_up (
        .clk   (clk),
        .rst_n (rst_n),
        .count (counter1),
        .wrap  (wrap_up)
    );

    parallel_counter_cell #(
        .MAX_COUNT (MAX_COUNT),
        .DIR       (CNT_DOWN)
    ) u_cnt_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .count (counter2),
        .wrap  (wrap_dn)
    );

`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
    assign wrap1 = wrap_up;
    assign wrap2 = wrap_dn;
`else
    // Without the option the pulses have no consumer; the registers
    // behind them are trimmed away.
    logic wrap_pair_unused;
    assign wrap_pair_unused = wrap_up ^ wrap_dn;
`endif

endmodule : parallel_counter

// File: tb/tb_parallel_counter.sv
// tb/tb_parallel_counter.sv - directed self-checking bench for parallel_counter

module tb_parallel_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst_n_b;
    logic [3:0] c1, c2;
    logic [3:0] c1_16, c2_16;
    logic [3:0] c1_2, c2_2;
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
    logic       w1, w2, w1_16, w2_16, w1_2, w2_2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parallel_counter #(.MAX_COUNT(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .counter1 (c1),
        .counter2 (c2)
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
        ,
        .wrap1    (w1),
        .wrap2    (w2)
`endif
    );

    parallel_counter #(.MAX_COUNT(16)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n_b),
        .counter1 (c1_16),
        .counter2 (c2_16)
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
        ,
        .wrap1    (w1_16),
        .wrap2    (w2_16)
`endif
    );

    parallel_counter #(.MAX_COUNT(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n_b),
        .counter1 (c1_2),
        .counter2 (c2_2)
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
        ,
        .wrap1    (w1_2),
        .wrap2    (w2_2)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp1 [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int exp2 [10] = '{6, 5, 4, 3, 2, 1, 0, 7, 6, 5};

    initial begin
        rst_n   = 1'b0;
        rst_n_b = 1'b0;

        // T1: two reset edges
        step();
        step();
        check("t1_reset_c1", int'(c1), 0);
        check("t1_reset_c2", int'(c2), 7);
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
        check("t1_reset_w1", int'(w1), 0);
        check("t1_reset_w2", int'(w2), 0);
`endif

        // T2: ten counting edges
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t2_c1[%0d]", i), int'(c1), exp1[i]);
            check($sformatf("t2_c2[%0d]", i), int'(c2), exp2[i]);
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
            check($sformatf("t2_w1[%0d]", i), int'(w1), (i == 7) ? 1 : 0);
            check($sformatf("t2_w2[%0d]", i), int'(w2), (i == 7) ? 1 : 0);
`endif
        end

        // T3 + T6: 40 more edges; counter1 started this phase at 2
        for (int k = 1; k <= 40; k++) begin
            step();
            check($sformatf("t3_sum[%0d]", k), int'(c1) + int'(c2), 7);
            check($sformatf("t3_c1[%0d]", k), int'(c1), (2 + k) % 8);
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
            check($sformatf("t6_w1[%0d]", k), int'(w1), ((2 + k) % 8 == 0) ? 1 : 0);
            check($sformatf("t6_w2[%0d]", k), int'(w2), ((2 + k) % 8 == 0) ? 1 : 0);
`endif
        end

        // T4: advance 2 -> 5, then one reset edge
        for (int k = 0; k < 3; k++) step();
        check("t4_pre_c1", int'(c1), 5);
        check("t4_pre_c2", int'(c2), 2);
        rst_n = 1'b0;
        step();
        check("t4_rst_c1", int'(c1), 0);
        check("t4_rst_c2", int'(c2), 7);
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
        check("t4_rst_w1", int'(w1), 0);
        check("t4_rst_w2", int'(w2), 0);
`endif
        rst_n = 1'b1;
        step();
        check("t4_resume_c1", int'(c1), 1);
        check("t4_resume_c2", int'(c2), 6);
        step();
        check("t4_resume2_c1", int'(c1), 2);
        check("t4_resume2_c2", int'(c2), 5);

        // T5: boundary moduli, held in reset until now
        check("t5_rst16_c1", int'(c1_16), 0);
        check("t5_rst16_c2", int'(c2_16), 15);
        check("t5_rst2_c1", int'(c1_2), 0);
        check("t5_rst2_c2", int'(c2_2), 1);
        rst_n_b = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("t5_16_c1[%0d]", k), int'(c1_16), k % 16);
            check($sformatf("t5_16_c2[%0d]", k), int'(c2_16), 15 - (k % 16));
            check($sformatf("t5_2_c1[%0d]", k), int'(c1_2), k % 2);
            check($sformatf("t5_2_c2[%0d]", k), int'(c2_2), 1 - (k % 2));
`ifdef PARALLEL_COUNTER_WRAP_FLAGS_EN
            check($sformatf("t5_16_w1[%0d]", k), int'(w1_16), (k == 16) ? 1 : 0);
            check($sformatf("t5_2_w2[%0d]", k), int'(w2_2), (k % 2 == 0) ? 1 : 0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_parallel_counter
